bayer_stream_gen: RTL and testbench

- Synthesisable, parametrised successor to the ISP bench's raw-stream producer.
- Accepts full RGB pixels and emits a Bayer-mosaiced raw stream with frame framing: a newFrame pulse, a pre-frame gap, per-row horizontal blanking, and a post-frame flush.
- Sits in front of processing (demosaic → filter → rgb2ycc → ycc2rgb). Drives its newFrame/iValid/iData inputs on hardware and in regression.
- Adds what the bench producer lacks: selectable CFA pattern, valid/ready input handshake, done-driven flush with timeout, and position outputs.

---
 rtl/bayer_stream_gen_if.sv | 41 ++++
 rtl/bayer_stream_gen.sv | 228 ++++++++++++++++++++++
 tb/tb_bayer_stream_gen.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bayer_stream_gen_if.sv
// Bayer stream generator bus bundle.
// Carries the frame-control, pixel-input and raw-output signals of
// bayer_stream_gen. The design side uses modport slave; the producer/consumer
// side (top-level glue or a bench) uses modport master.
//   iStart/iPattern  frame request and CFA select
//   iValid/oReady    RGB pixel handshake, iR/iG/iB pixel channels
//   iDone            downstream frame-complete indication
//   newFrame/oValid/oData/oRow/oCol  raw mosaic output and position
//   oBusy/oFrameDone/oTimeout        status
interface bayer_stream_gen_if #(
  parameter int DATA_W = 8,
  parameter int ROW_W  = 8,
  parameter int COL_W  = 9
);
  logic              iStart;
  logic [1:0]        iPattern;
  logic              iValid;
  logic              oReady;
  logic [DATA_W-1:0] iR;
  logic [DATA_W-1:0] iG;
  logic [DATA_W-1:0] iB;
  logic              iDone;
  logic              newFrame;
  logic              oValid;
  logic [DATA_W-1:0] oData;
  logic [ROW_W-1:0]  oRow;
  logic [COL_W-1:0]  oCol;
  logic              oBusy;
  logic              oFrameDone;
  logic              oTimeout;

  modport master (
    output iStart, iPattern, iValid, iR, iG, iB, iDone,
    input  oReady, newFrame, oValid, oData, oRow, oCol, oBusy, oFrameDone, oTimeout
  );

  modport slave (
    input  iStart, iPattern, iValid, iR, iG, iB, iDone,
    output oReady, newFrame, oValid, oData, oRow, oCol, oBusy, oFrameDone, oTimeout
  );
endinterface

// File: rtl/bayer_stream_gen.sv
// Bayer raw-stream generator.
// Accepts RGB pixels over a valid/ready handshake and emits a CFA-mosaiced raw
// stream framed as: newFrame pulse, pre-frame gap, active rows each followed by
// horizontal blanking, then zero-valued flush rows until downstream reports
// done (or MAX_FLUSH rows elapse, which raises sticky oTimeout).
// Ports:
//   clk    clock
//   reset  asynchronous active-low reset
//   bus    bayer_stream_gen_if.slave (handshake, pixel, status signals)
module bayer_stream_gen #(
  parameter int width     = 320,
  parameter int height    = 240,
  parameter int DATA_W    = 8,
  parameter int H_BLANK   = 16,
  parameter int PRE_GAP   = 31,
  parameter int MAX_FLUSH = 8
) (
  input  logic                clk,
  input  logic                reset,
  bayer_stream_gen_if.slave   bus
);

  localparam int ROW_W   = (height > 1) ? $clog2(height) : 1;
  localparam int COL_W   = (width > 1) ? $clog2(width) : 1;
  localparam int CNT_A   = (width > H_BLANK) ? width : H_BLANK;
  localparam int CNT_MAX = (CNT_A > PRE_GAP) ? CNT_A : PRE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FL_W    = (MAX_FLUSH > 0) ? $clog2(MAX_FLUSH + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_SOF, S_GAP, S_ACTIVE, S_HBLANK, S_FLUSH, S_FBLANK, S_DONE
  } state_e;

  typedef enum logic [1:0] {
    CFA_GBRG, CFA_GRBG, CFA_RGGB, CFA_BGGR
  } cfa_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic               last_row_q, last_row_d;
  logic [FL_W-1:0]    flush_q, flush_d;
  cfa_e               pat_q, pat_d;
  logic               done_seen_q, done_seen_d;
  logic               timeout_q, timeout_d;
  logic               valid_q, valid_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [ROW_W-1:0]   orow_q, orow_d;
  logic [COL_W-1:0]   ocol_q, ocol_d;

  logic in_frame;
  logic row_done, hblank_end, flush_row_done, fblank_end;

  // Colour at phase (pr,pc): diagonal phases (0,0)/(1,1) versus the two
  // off-diagonal ones; pr selects which of the pair within each group.
  function automatic logic [DATA_W-1:0] cfa_pick(
    input cfa_e              pat,
    input logic              pr,
    input logic              pc,
    input logic [DATA_W-1:0] r,
    input logic [DATA_W-1:0] g,
    input logic [DATA_W-1:0] b
  );
    logic diag;
    diag = (pr == pc);
    unique case (pat)
      CFA_GBRG: return diag ? g : (pr ? r : b);
      CFA_GRBG: return diag ? g : (pr ? b : r);
      CFA_RGGB: return diag ? (pr ? b : r) : g;
      CFA_BGGR: return diag ? (pr ? r : b) : g;
    endcase
  endfunction

  assign in_frame = state_q inside {S_ACTIVE, S_HBLANK, S_FLUSH, S_FBLANK};

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    col_d          = col_q;
    row_d          = row_q;
    last_row_d     = last_row_q;
    flush_d        = flush_q;
    pat_d          = pat_q;
    timeout_d      = timeout_q;
    done_seen_d    = done_seen_q | (bus.iDone & in_frame);
    valid_d        = 1'b0;
    data_d         = '0;
    orow_d         = '0;
    ocol_d         = '0;
    row_done       = 1'b0;
    hblank_end     = 1'b0;
    flush_row_done = 1'b0;
    fblank_end     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.iStart) begin
          state_d     = S_SOF;
          pat_d       = cfa_e'(bus.iPattern);
          timeout_d   = 1'b0;
          done_seen_d = 1'b0;
        end
      end
      S_SOF: begin
        cnt_d      = '0;
        col_d      = '0;
        row_d      = '0;
        last_row_d = 1'b0;
        flush_d    = '0;
        state_d    = (PRE_GAP == 0) ? S_ACTIVE : S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(PRE_GAP - 1)) begin
          cnt_d   = '0;
          state_d = S_ACTIVE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_ACTIVE: begin
        if (bus.iValid) begin
          valid_d = 1'b1;
          data_d  = cfa_pick(pat_q, row_q[0], col_q[0], bus.iR, bus.iG, bus.iB);
          orow_d  = row_q;
          ocol_d  = col_q;
          if (col_q == COL_W'(width - 1)) begin
            col_d    = '0;
            row_done = 1'b1;
            // Row index saturates on the last row; the flag remembers that
            // the frame's active region is finished.
            if (row_q == ROW_W'(height - 1)) last_row_d = 1'b1;
            else                             row_d      = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      S_HBLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) hblank_end = 1'b1;
        else                              cnt_d      = cnt_q + CNT_W'(1);
      end
      S_FLUSH: begin
        valid_d = 1'b1;
        orow_d  = ROW_W'(height - 1);
        ocol_d  = COL_W'(cnt_q);
        if (cnt_q == CNT_W'(width - 1)) flush_row_done = 1'b1;
        else                            cnt_d          = cnt_q + CNT_W'(1);
      end
      S_FBLANK: begin
        if (cnt_q == CNT_W'(H_BLANK - 1)) fblank_end = 1'b1;
        else                              cnt_d      = cnt_q + CNT_W'(1);
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Row and flush-row boundaries are resolved here so that a zero-length
    // blanking interval skips the blank state instead of needing one cycle.
    if (row_done && (H_BLANK != 0)) begin
      state_d = S_HBLANK;
      cnt_d   = '0;
    end else if (row_done || hblank_end) begin
      state_d = last_row_d ? S_FLUSH : S_ACTIVE;
      cnt_d   = '0;
    end

    if (flush_row_done) flush_d = flush_q + FL_W'(1);

    if (flush_row_done && (H_BLANK != 0)) begin
      state_d = S_FBLANK;
      cnt_d   = '0;
    end else if (flush_row_done || fblank_end) begin
      cnt_d = '0;
      if (done_seen_d) begin
        state_d = S_DONE;
      end else if (flush_d == FL_W'(MAX_FLUSH)) begin
        state_d   = S_DONE;
        timeout_d = 1'b1;
      end else begin
        state_d = S_FLUSH;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      col_q       <= '0;
      row_q       <= '0;
      last_row_q  <= 1'b0;
      flush_q     <= '0;
      pat_q       <= CFA_GBRG;
      done_seen_q <= 1'b0;
      timeout_q   <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      last_row_q  <= last_row_d;
      flush_q     <= flush_d;
      pat_q       <= pat_d;
      done_seen_q <= done_seen_d;
      timeout_q   <= timeout_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      orow_q      <= orow_d;
      ocol_q      <= ocol_d;
    end
  end

  assign bus.oReady     = (state_q == S_ACTIVE);
  assign bus.newFrame   = (state_q == S_SOF);
  assign bus.oBusy      = (state_q != S_IDLE);
  assign bus.oFrameDone = (state_q == S_DONE);
  assign bus.oTimeout   = timeout_q;
  assign bus.oValid     = valid_q;
  assign bus.oData      = data_q;
  assign bus.oRow       = orow_q;
  assign bus.oCol       = ocol_q;

endmodule

// File: tb/tb_bayer_stream_gen.sv
module tb_bayer_stream_gen;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int DW = 8;
  localparam int HB = 2;
  localparam int PG = 3;
  localparam int MF = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bayer_stream_gen_if #(.DATA_W(DW), .ROW_W($clog2(H)), .COL_W($clog2(W))) bus ();

  bayer_stream_gen #(
    .width(W), .height(H), .DATA_W(DW), .H_BLANK(HB), .PRE_GAP(PG), .MAX_FLUSH(MF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  int q[$];
  int cyc = 0;
  int nf_cnt = 0, fd_cnt = 0, flush_seen = 0;
  int nf_cyc = 0, first_v_cyc = -1, r0c3_cyc = 0, r1c0_cyc = 0;
  string pats [4] = '{"GBRG", "GRBG", "RGGB", "BGGR"};

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int pk(input int d, input int r, input int c);
    return (d << 8) | (r << 4) | c;
  endfunction

  // Reference mosaic: colour letter from the pattern name at phase (r%2,c%2).
  function automatic int model(input int p, input int r, input int c);
    string s;
    byte ch;
    int idx;
    s   = pats[p];
    ch  = s[(r % 2) * 2 + (c % 2)];
    idx = r * W + c;
    if (ch == "R")      return idx + 30;
    else if (ch == "G") return idx + 10;
    else                return idx + 20;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      if (bus.newFrame) begin
        nf_cnt++;
        nf_cyc = cyc;
        first_v_cyc = -1;
      end
      if (bus.oFrameDone) fd_cnt++;
      if (bus.oValid) begin
        if (first_v_cyc < 0) first_v_cyc = cyc;
        if (bus.oData == 0) flush_seen++;
        if (bus.oData != 0 && bus.oRow == 0 && bus.oCol == 3) r0c3_cyc = cyc;
        if (bus.oData != 0 && bus.oRow == 1 && bus.oCol == 0) r1c0_cyc = cyc;
        chk("sb_nonempty", 32'(q.size() != 0), 1);
        if (q.size() != 0)
          chk("pixel", {16'd0, bus.oData, 3'd0, bus.oRow, 2'd0, bus.oCol}, q.pop_front());
      end
    end
  end

  task automatic run_frame(input int p, input bit throttle, input bit pulse_done,
                           input int exp_flush, input bit exp_to, input int abort_idx,
                           input bit poke_start);
    int idx, b, nf0, fd0, fs0;
    bit vtog;
    idx = 0; b = 0; vtog = 1'b1;
    nf0 = nf_cnt; fd0 = fd_cnt;
    @(posedge clk); #1;
    bus.iPattern = 2'(p);
    bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    bus.iPattern = 2'((p + 1) % 4);
    while (idx < W * H && b < 200) begin
      bus.iValid = throttle ? vtog : 1'b1;
      vtog = ~vtog;
      bus.iG = DW'(idx + 10);
      bus.iB = DW'(idx + 20);
      bus.iR = DW'(idx + 30);
      bus.iStart = poke_start && (idx == 5);
      @(negedge clk);
      if (bus.iValid && bus.oReady) begin
        q.push_back(pk(model(p, idx / W, idx % W), idx / W, idx % W));
        idx++;
      end
      if (idx == abort_idx) begin
        #2 reset = 1'b0;
        #1;
        chk("abort_valid", bus.oValid, 0);
        chk("abort_ready", bus.oReady, 0);
        chk("abort_busy", bus.oBusy, 0);
        q.delete();
        bus.iValid = 1'b0;
        bus.iStart = 1'b0;
        repeat (3) @(posedge clk);
        chk("abort_no_done", fd_cnt - fd0, 0);
        @(negedge clk);
        reset = 1'b1;
        return;
      end
      @(posedge clk); #1;
      b++;
    end
    bus.iValid = 1'b0;
    bus.iStart = 1'b0;
    chk("accepted", idx, W * H);
    for (int f = 0; f < exp_flush; f++)
      for (int c = 0; c < W; c++) q.push_back(pk(0, H - 1, c));
    fs0 = flush_seen;
    b = 0;
    while (flush_seen == fs0 && b < 100) begin
      @(posedge clk);
      b++;
    end
    chk("flush_started", 32'(flush_seen > fs0), 1);
    #1;
    bus.iDone = pulse_done;
    bus.iStart = poke_start;
    bus.iPattern = 2'((p + 2) % 4);
    @(posedge clk); #1;
    bus.iDone = 1'b0;
    bus.iStart = 1'b0;
    b = 0;
    while (fd_cnt == fd0 && b < 200) begin
      @(posedge clk);
      b++;
    end
    #1;
    chk("frame_done", fd_cnt - fd0, 1);
    chk("newframe_once", nf_cnt - nf0, 1);
    chk("timeout", bus.oTimeout, exp_to);
    chk("flush_items", flush_seen - fs0, exp_flush * W);
    chk("sb_drained", q.size(), 0);
    chk("idle_after_done", bus.oBusy, 0);
    if (!throttle) begin
      chk("latency", first_v_cyc - nf_cyc, PG + 2);
      chk("hblank_gap", r1c0_cyc - r0c3_cyc, HB + 1);
    end
  endtask

  initial begin
    bus.iStart = 1'b0;
    bus.iPattern = 2'd0;
    bus.iValid = 1'b0;
    bus.iR = '0;
    bus.iG = '0;
    bus.iB = '0;
    bus.iDone = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", bus.oValid, 0);
    chk("rst_ready", bus.oReady, 0);
    chk("rst_busy", bus.oBusy, 0);
    chk("rst_newframe", bus.newFrame, 0);
    chk("rst_framedone", bus.oFrameDone, 0);
    chk("rst_timeout", bus.oTimeout, 0);
    chk("rst_data", {bus.oData, bus.oRow, bus.oCol}, 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    run_frame(0, 1'b0, 1'b0, 2, 1'b1, -1, 1'b0);
    run_frame(2, 1'b0, 1'b1, 1, 1'b0, -1, 1'b0);
    run_frame(3, 1'b0, 1'b1, 1, 1'b0, -1, 1'b1);
    run_frame(1, 1'b1, 1'b1, 1, 1'b0, -1, 1'b0);
    run_frame(0, 1'b0, 1'b0, 0, 1'b0, 6, 1'b0);
    chk("post_abort_timeout", bus.oTimeout, 0);
    run_frame(0, 1'b0, 1'b0, 2, 1'b1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
